// File: rtl/acc_datapath_p.sv
// Accumulator datapath: PC/IR/MAR, ACC, register file, ALU/shifter,
// NCZ flags, return-address stack and a valid/ready output register.
module acc_datapath_p #(
  parameter int DW     = 8,
  parameter int AW     = 6,
  parameter int NREG   = 8,
  parameter int SDEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] readdata,
  input  logic [DW-1:0] in_data,
  input  logic          ir_load,
  input  logic          mar_load,
  input  logic          pc_load,
  input  logic [2:0]    pc_sel,
  input  logic          mem_inst,
  input  logic          acc_load,
  input  logic [1:0]    acc_sel,
  input  logic          rf_wr,
  input  logic [2:0]    alu_sel,
  input  logic [1:0]    shift_sel,
  input  logic          flag_load,
  input  logic          push,
  input  logic          pop,
  input  logic          out_en,
  input  logic          out_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] address,
  output logic [DW-1:0] acc_out,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_stall,
  output logic [2:0]    flags,
  output logic          stack_empty,
  output logic          stack_full,
  output logic          stack_err
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(SDEPTH);
  localparam int CW = SW + 1;

  logic [AW-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DW-1:0] ir_q, ir_d, acc_q, acc_d;
  logic [DW-1:0] od_q, od_d;
  logic          ov_q, ov_d;
  logic [2:0]    fl_q, fl_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic [AW-1:0] stk_q [SDEPTH];
  logic [AW-1:0] stk_d [SDEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [RW-1:0] rsel;
  logic [DW-1:0] rf_out, sh;
  logic [DW:0]   alu_w;
  logic          alu_c;
  logic [AW-1:0] pc_inc, offset, top;
  logic [SW-1:0] top_idx;
  logic          empty, full, acc_ok;

  assign rsel    = ir_q[RW-1:0];
  assign rf_out  = rf_q[rsel];
  assign offset  = ir_q[AW-1:0];
  assign pc_inc  = pc_q + AW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(SDEPTH));
  assign top_idx = cnt_q[SW-1:0] - SW'(1);
  assign top     = empty ? '0 : stk_q[top_idx];

  assign instr       = ir_q;
  assign address     = mem_inst ? mar_q : pc_q;
  assign acc_out     = acc_q;
  assign out_data    = od_q;
  assign out_valid   = ov_q;
  assign out_stall   = ov_q & ~out_ready;
  assign flags       = fl_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign stack_err   = err_q;

  // ALU with a DW+1 bit result so bit DW is carry or borrow
  always_comb begin
    alu_w = '0;
    alu_c = 1'b0;
    unique case (alu_sel)
      3'd0: alu_w = {1'b0, acc_q} + {1'b0, rf_out};
      3'd1: alu_w = {1'b0, acc_q} - {1'b0, rf_out};
      3'd2: alu_w = {1'b0, acc_q & rf_out};
      3'd3: alu_w = {1'b0, acc_q | rf_out};
      3'd4: alu_w = {1'b0, acc_q ^ rf_out};
      3'd5: alu_w = {1'b0, ~acc_q};
      3'd6: alu_w = {1'b0, acc_q} + (DW+1)'(1);
      3'd7: alu_w = {1'b0, acc_q} - (DW+1)'(1);
    endcase
    alu_c = alu_w[DW];
  end

  // Shifter on the ALU result
  always_comb begin
    sh = alu_w[DW-1:0];
    unique case (shift_sel)
      2'd0: sh = alu_w[DW-1:0];
      2'd1: sh = {alu_w[DW-2:0], 1'b0};
      2'd2: sh = {1'b0, alu_w[DW-1:1]};
      2'd3: sh = {alu_w[0], alu_w[DW-1:1]};
    endcase
  end

  // PC/IR/MAR/ACC/flags/RF next-state
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_load ? readdata : ir_q;
    mar_d = mar_load ? readdata[AW-1:0] : mar_q;
    acc_d = acc_q;
    fl_d  = fl_q;
    rf_d  = rf_q;
    if (pc_load) begin
      unique case (pc_sel)
        3'd0:    pc_d = pc_inc;
        3'd1:    pc_d = readdata[AW-1:0];
        3'd2:    pc_d = pc_q - offset;
        3'd3:    pc_d = pc_q + offset;
        3'd4:    pc_d = top;
        default: pc_d = pc_q;
      endcase
    end
    if (acc_load) begin
      unique case (acc_sel)
        2'd0: acc_d = sh;
        2'd1: acc_d = rf_out;
        2'd2: acc_d = in_data;
        2'd3: acc_d = readdata;
      endcase
    end
    if (flag_load) fl_d = {sh[DW-1], alu_c, (sh == '0)};
    if (rf_wr) rf_d[rsel] = acc_q;
  end

  // Return stack; push with pop on a non-empty stack swaps the top
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push && pop) begin
      if (empty) begin
        stk_d[0] = pc_inc;
        cnt_d    = CW'(1);
        err_d    = 1'b1;
      end else begin
        stk_d[top_idx] = pc_inc;
      end
    end else if (push) begin
      if (full) err_d = 1'b1;
      else begin
        stk_d[cnt_q[SW-1:0]] = pc_inc;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop) begin
      if (empty) err_d = 1'b1;
      else cnt_d = cnt_q - CW'(1);
    end
  end

  // Output register handshake
  always_comb begin
    acc_ok = out_en & (~ov_q | out_ready);
    od_d   = od_q;
    ov_d   = ov_q;
    if (acc_ok) begin
      od_d = acc_q;
      ov_d = 1'b1;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  // State registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      acc_q <= '0;
      fl_q  <= '0;
      od_q  <= '0;
      ov_q  <= 1'b0;
      rf_q  <= '{default: '0};
      stk_q <= '{default: '0};
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      acc_q <= acc_d;
      fl_q  <= fl_d;
      od_q  <= od_d;
      ov_q  <= ov_d;
      rf_q  <= rf_d;
      stk_q <= stk_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule
